// File: rtl/modcounter_pro_pkg.sv
// rtl/modcounter_pro_pkg.sv - step mode encodings and width helper for modcounter_pro
package modcounter_pro_pkg;

    localparam logic [2:0] MODE_UP    = 3'd0;
    localparam logic [2:0] MODE_DOWN  = 3'd1;
    localparam logic [2:0] MODE_PP    = 3'd2;
    localparam logic [2:0] MODE_LOAD  = 3'd3;
    localparam logic [2:0] MODE_UPSAT = 3'd4;
    localparam logic [2:0] MODE_DNSAT = 3'd5;
    localparam logic [2:0] MODE_HOLD  = 3'd6;

    // Never returns 0 so that a value of 1 still yields a usable 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/modcounter_pro_btn_debounce.sv
// rtl/modcounter_pro_btn_debounce.sv - button synchroniser, debounce window and auto-repeat
module modcounter_pro_btn_debounce
    import modcounter_pro_pkg::*;
#(
    parameter int DEB_CYCLES    = 2000000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic step_o
);

    localparam int DW = clog2(DEB_CYCLES + 1);
    localparam int RW = clog2(REPEAT_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic          syn1_q;
    logic          syn2_q;
    logic [DW-1:0] deb_q;
    logic [RW-1:0] rep_q;
    logic          step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn1_q <= 1'b0;
            syn2_q <= 1'b0;
            deb_q  <= '0;
            rep_q  <= '0;
            step_q <= 1'b0;
        end else begin
            syn1_q <= btn_i;
            syn2_q <= syn1_q;
            step_q <= 1'b0;
            if (!syn2_q) begin
                deb_q <= '0;
                rep_q <= '0;
            end else if (deb_q != DEB_MAX) begin
                deb_q <= deb_q + DW'(1);
                step_q <= (deb_q == DEB_MAX - DW'(1));
            end else if (REPEAT_CYCLES > 0) begin
                // Repeat window only runs once the press is accepted and held.
                if (rep_q == REP_LAST) begin
                    rep_q  <= '0;
                    step_q <= 1'b1;
                end else begin
                    rep_q <= rep_q + RW'(1);
                end
            end
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/modcounter_pro.sv
// rtl/modcounter_pro.sv - debounced modulo counter with wrap, ping-pong, load and saturating modes
module modcounter_pro
    import modcounter_pro_pkg::*;
#(
    parameter int N             = 16,
    parameter int DEB_CYCLES    = 2000000,
    parameter int REPEAT_CYCLES = 0,
    localparam int W            = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_in,
    input  logic [2:0]   ctrl,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] count,
    output logic [N-1:0] t_count,
    output logic         dir,
    output logic         wrap,
    output logic         sat
);

    localparam logic [W-1:0] MAX = W'(N - 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic         step;
    logic [W-1:0] count_q, count_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         sat_q, sat_d;

    modcounter_pro_btn_debounce #(
        .DEB_CYCLES    (DEB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_in),
        .step_o (step)
    );

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        sat_d   = sat_q;
        wrap_d  = 1'b0;
        if (step) begin
            dir_d = 1'b0;
            sat_d = 1'b0;
            case (ctrl)
                MODE_UP: begin
                    if (count_q == MAX) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (count_q == '0) begin
                        count_d = MAX;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                MODE_PP: begin
                    dir_d = dir_q;
                    if (!dir_q && count_q == MAX) begin
                        dir_d   = 1'b1;
                        count_d = MAX - ONE;
                        wrap_d  = 1'b1;
                    end else if (dir_q && count_q == '0) begin
                        dir_d   = 1'b0;
                        count_d = ONE;
                        wrap_d  = 1'b1;
                    end else if (dir_q) begin
                        count_d = count_q - ONE;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                // Out-of-range loads fall back to 0 so count never leaves 0..N-1.
                MODE_LOAD: count_d = (int'(load_data) < N) ? load_data : '0;
                MODE_UPSAT: begin
                    if (count_q == MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                        sat_d   = (count_q == MAX - ONE);
                    end
                end
                MODE_DNSAT: begin
                    if (count_q == '0) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                        sat_d   = (count_q == ONE);
                    end
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        t_count = '0;
        for (int i = 0; i < N; i++) begin
            t_count[i] = (i < int'(count_q));
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign wrap  = wrap_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_modcounter_pro.sv
// tb/tb_modcounter_pro.sv - self-checking bench for modcounter_pro (N=5, DEB_CYCLES=4, REPEAT_CYCLES=6)
module tb_modcounter_pro;

    localparam int N   = 5;
    localparam int DEB = 4;
    localparam int REP = 6;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic [2:0] ctrl;
    logic [2:0] load_data;
    logic [2:0] count;
    logic [4:0] t_count;
    logic       dir;
    logic       wrap;
    logic       sat;

    int n_vec;
    int n_err;

    int m_count;
    bit m_dir;
    bit m_wrap;
    bit m_sat;
    int run;
    int rq[3];

    typedef struct {
        int ctrl;
        int load;
        int cnt;
        bit dir;
        bit wrap;
        bit sat;
    } press_t;

    press_t tbl[15];

    modcounter_pro #(
        .N             (N),
        .DEB_CYCLES    (DEB),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .ctrl      (ctrl),
        .load_data (load_data),
        .count     (count),
        .t_count   (t_count),
        .dir       (dir),
        .wrap      (wrap),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string name, input int c, input bit d, input bit w, input bit s);
        logic [4:0] t_exp;
        t_exp = 5'((1 << c) - 1);
        n_vec++;
        if (count !== 3'(c) || t_count !== t_exp || dir !== d || wrap !== w || sat !== s) begin
            n_err++;
            $display("FAIL %s @%0t: got count=%0d t=%b dir=%b wrap=%b sat=%b, want count=%0d t=%b dir=%0d wrap=%0d sat=%0d",
                     name, $time, count, t_count, dir, wrap, sat, c, t_exp, d, w, s);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_dir   = 0;
        m_wrap  = 0;
        m_sat   = 0;
        run     = 0;
        rq[0]   = 0;
        rq[1]   = 0;
        rq[2]   = 0;
    endtask

    task automatic apply_mode(input int mode, input int ld);
        bit prev_dir;
        prev_dir = m_dir;
        m_dir = 0;
        m_sat = 0;
        case (mode)
            0: begin m_wrap = (m_count == N - 1); m_count = (m_count + 1) % N; end
            1: begin m_wrap = (m_count == 0); m_count = (m_count + N - 1) % N; end
            2: begin
                if (!prev_dir && m_count == N - 1) begin
                    m_dir = 1; m_count = N - 2; m_wrap = 1;
                end else if (prev_dir && m_count == 0) begin
                    m_dir = 0; m_count = 1; m_wrap = 1;
                end else begin
                    m_dir = prev_dir;
                    m_count = prev_dir ? m_count - 1 : m_count + 1;
                end
            end
            3: m_count = (ld < N) ? ld : 0;
            4: begin m_count = (m_count + 1 > N - 1) ? N - 1 : m_count + 1; m_sat = (m_count == N - 1); end
            5: begin m_count = (m_count == 0) ? 0 : m_count - 1; m_sat = (m_count == 0); end
            default: ;
        endcase
    endtask

    // A step lands DEB+2 edges after the first high sample; r is the
    // length of the unbroken high run as seen three edges ago.
    task automatic model_edge();
        int  r;
        bit  stp;
        if (rst) begin
            model_reset();
            return;
        end
        r = rq[2];
        stp = (r == DEB) || (REP > 0 && r > DEB && ((r - DEB) % REP) == 0);
        m_wrap = 0;
        if (stp) apply_mode(int'(ctrl), int'(load_data));
        run = btn_in ? run + 1 : 0;
        rq[2] = rq[1];
        rq[1] = rq[0];
        rq[0] = run;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        expect_out("model", m_count, m_dir, m_wrap, m_sat);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        model_reset();
        #1;
        expect_out("reset_async", 0, 0, 0, 0);
        repeat (cyc) tick();
        rst = 1'b0;
    endtask

    task automatic press(input int c, input int ld);
        ctrl      = 3'(c);
        load_data = 3'(ld);
        btn_in    = 1'b1;
        repeat (DEB + 3) tick();
        btn_in    = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        btn_in    = 1'b0;
        ctrl      = 3'd0;
        load_data = 3'd0;
        model_reset();

        tbl[0]  = '{2, 0, 1, 0, 0, 0};
        tbl[1]  = '{2, 0, 2, 0, 0, 0};
        tbl[2]  = '{2, 0, 3, 0, 0, 0};
        tbl[3]  = '{2, 0, 4, 0, 0, 0};
        tbl[4]  = '{2, 0, 3, 1, 1, 0};
        tbl[5]  = '{2, 0, 2, 1, 0, 0};
        tbl[6]  = '{2, 0, 1, 1, 0, 0};
        tbl[7]  = '{2, 0, 0, 1, 0, 0};
        tbl[8]  = '{2, 0, 1, 0, 1, 0};
        tbl[9]  = '{2, 0, 2, 0, 0, 0};
        tbl[10] = '{3, 7, 0, 0, 0, 0};
        tbl[11] = '{3, 3, 3, 0, 0, 0};
        tbl[12] = '{4, 0, 4, 0, 0, 1};
        tbl[13] = '{4, 0, 4, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 1, 0};

        repeat (2) tick();
        expect_out("reset_state", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single clean press: exact latency of DEB+2 edges.
        ctrl   = 3'd0;
        btn_in = 1'b1;
        repeat (DEB + 2) tick();
        expect_out("t1_before_step", 0, 0, 0, 0);
        tick();
        expect_out("t1_step", 1, 0, 0, 0);
        btn_in = 1'b0;
        repeat (6) tick();
        expect_out("t1_single", 1, 0, 0, 0);

        // Bounce never completes the window.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            repeat (3) tick();
            btn_in = 1'b0;
            repeat (2) tick();
        end
        repeat (4) tick();
        expect_out("t2_bounce", 0, 0, 0, 0);

        do_reset(1);
        for (int i = 0; i < 15; i++) begin
            press(tbl[i].ctrl, tbl[i].load);
            expect_out($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].dir, tbl[i].wrap, tbl[i].sat);
            repeat (6) tick();
        end

        // Held press with auto-repeat in down-wrap mode.
        do_reset(1);
        ctrl   = 3'd1;
        btn_in = 1'b1;
        repeat (DEB + 3) tick();
        expect_out("t4_first", 4, 0, 1, 0);
        for (int j = 1; j <= 3; j++) begin
            repeat (REP - 1) tick();
            expect_out($sformatf("t4_pre_rep%0d", j), 5 - j, 0, 0, 0);
            tick();
            expect_out($sformatf("t4_rep%0d", j), 4 - j, 0, 0, 0);
        end
        btn_in = 1'b0;
        repeat (8) tick();
        expect_out("t4_release", 1, 0, 0, 0);

        // Reset mid-press restarts the full window.
        do_reset(1);
        ctrl   = 3'd0;
        btn_in = 1'b1;
        repeat (4) tick();
        do_reset(2);
        repeat (DEB + 2) tick();
        expect_out("t6_no_early_step", 0, 0, 0, 0);
        tick();
        expect_out("t6_step", 1, 0, 0, 0);
        btn_in = 1'b0;
        repeat (6) tick();

        begin
            int seg;
            seg = 0;
            for (int i = 0; i < 1500; i++) begin
                if (seg == 0) begin
                    btn_in = ~btn_in;
                    seg = btn_in ? $urandom_range(1, 26) : $urandom_range(1, 6);
                end
                seg--;
                ctrl      = 3'($urandom_range(0, 7));
                load_data = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
